// File: rtl/gpu_sched_pkg.sv
// Shared types and constants for the frame scheduler and its watchdog.
package gpu_sched_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2**24;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CLEAR_WAIT,
    RENDER,
    RENDER_WAIT,
    SWAP_WAIT,
    ERROR
  } sched_state_e;

endpackage

// File: rtl/sched_watchdog.sv
// Cycle counter that flags a stalled wait state in the frame scheduler.
module sched_watchdog
  import gpu_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // expired marks the edge on which the count would reach TIMEOUT_CYCLES-1,
  // so the error is visible in cycle TIMEOUT_CYCLES of the wait.
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES >= 2) ? CW'(TIMEOUT_CYCLES - 2) : '0;

  logic [CW-1:0] count_q, count_d;

  assign expired = run && (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: clear, render, then swap the double buffer on vsync,
// with a watchdog guarding each wait for the clear engine and rasterizer.
module frame_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [31:0]       vertex_count_in,
  input  logic [ADDR_W-1:0] fb_base0,
  input  logic [ADDR_W-1:0] fb_base1,
  output logic              clear_start,
  input  logic              clear_done,
  output logic              gpu_start,
  output logic [31:0]       gpu_vertex_count,
  input  logic              gpu_frame_end,
  output logic [ADDR_W-1:0] render_base,
  output logic [ADDR_W-1:0] display_base,
  input  logic              vsync,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic              timeout_err,
  input  logic              err_clear
);

  sched_state_e state_q, state_d;

  logic        wd_clear, wd_run, wd_expired;
  logic        swap;
  logic        back_sel_q, back_sel_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [31:0] vcount_q, vcount_d;
  logic        clear_start_q, clear_start_d;
  logic        gpu_start_q, gpu_start_d;
  logic        timeout_err_q, timeout_err_d;

  sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(wd_expired)
  );

  assign wd_run   = (state_q == CLEAR_WAIT) || (state_q == RENDER_WAIT);
  assign wd_clear = (state_d != state_q);
  assign swap     = (state_q == SWAP_WAIT) && vsync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Awaited pulses are tested before the watchdog so they win a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (enable) state_d = CLEAR;
      CLEAR:       state_d = CLEAR_WAIT;
      CLEAR_WAIT: begin
        if (clear_done)      state_d = (vcount_q != '0) ? RENDER : SWAP_WAIT;
        else if (wd_expired) state_d = ERROR;
      end
      RENDER:      state_d = RENDER_WAIT;
      RENDER_WAIT: begin
        if (gpu_frame_end)   state_d = SWAP_WAIT;
        else if (wd_expired) state_d = ERROR;
      end
      SWAP_WAIT:   if (vsync) state_d = enable ? CLEAR : IDLE;
      ERROR:       if (err_clear) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    clear_start_d = (state_d == CLEAR);
    gpu_start_d   = (state_d == RENDER);
    vcount_d      = (state_d == CLEAR) ? vertex_count_in : vcount_q;
    back_sel_d    = swap ? ~back_sel_q : back_sel_q;
    frame_count_d = swap ? frame_count_q + 16'd1 : frame_count_q;
    timeout_err_d = timeout_err_q;
    if ((state_q == ERROR) && err_clear) begin
      timeout_err_d = 1'b0;
    end else if (state_d == ERROR) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_start_q <= 1'b0;
      gpu_start_q   <= 1'b0;
      vcount_q      <= '0;
      back_sel_q    <= 1'b1;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      clear_start_q <= clear_start_d;
      gpu_start_q   <= gpu_start_d;
      vcount_q      <= vcount_d;
      back_sel_q    <= back_sel_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign clear_start      = clear_start_q;
  assign gpu_start        = gpu_start_q;
  assign gpu_vertex_count = vcount_q;
  assign render_base      = back_sel_q ? fb_base0 : fb_base1;
  assign display_base     = back_sel_q ? fb_base1 : fb_base0;
  assign busy             = (state_q != IDLE);
  assign frame_count      = frame_count_q;
  assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with a scoreboard for vertex counts and swaps.
module tb_frame_scheduler;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 64;
  localparam int          NFRAMES = 600;
  localparam logic [31:0] BASE0   = 32'h1000_0000;
  localparam logic [31:0] BASE1   = 32'h2000_0000;

  typedef struct packed {
    logic [31:0] render;
    logic [31:0] display;
    logic [15:0] count;
  } swapExp_t;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [31:0]       vertex_count_in;
  logic [ADDR_W-1:0] fb_base0, fb_base1;
  logic              clear_start, clear_done;
  logic              gpu_start, gpu_frame_end;
  logic [31:0]       gpu_vertex_count;
  logic [ADDR_W-1:0] render_base, display_base;
  logic              vsync, busy, timeout_err, err_clear;
  logic [15:0]       frame_count;

  int          checks = 0;
  int          errors = 0;
  int unsigned vcQ[$];
  swapExp_t    swapQ[$];
  swapExp_t    monS;
  logic        expBack;
  int          expFrames;
  logic [15:0] lastCount;

  frame_scheduler #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .vertex_count_in (vertex_count_in),
    .fb_base0        (fb_base0),
    .fb_base1        (fb_base1),
    .clear_start     (clear_start),
    .clear_done      (clear_done),
    .gpu_start       (gpu_start),
    .gpu_vertex_count(gpu_vertex_count),
    .gpu_frame_end   (gpu_frame_end),
    .render_base     (render_base),
    .display_base    (display_base),
    .vsync           (vsync),
    .busy            (busy),
    .frame_count     (frame_count),
    .timeout_err     (timeout_err),
    .err_clear       (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_clear_start"}, 64'(clear_start), 64'(0));
    checkOutput({tag, "_gpu_start"}, 64'(gpu_start), 64'(0));
    checkOutput({tag, "_frame_count"}, 64'(frame_count), 64'(0));
    checkOutput({tag, "_vcount"}, 64'(gpu_vertex_count), 64'(0));
    checkOutput({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    checkOutput({tag, "_render_base"}, 64'(render_base), 64'(BASE0));
    checkOutput({tag, "_display_base"}, 64'(display_base), 64'(BASE1));
  endtask

  // The model's back_sel toggles on every expected swap.
  task automatic pushSwap();
    swapExp_t s;
    expBack   = ~expBack;
    expFrames = expFrames + 1;
    s.render  = expBack ? BASE0 : BASE1;
    s.display = expBack ? BASE1 : BASE0;
    s.count   = 16'(expFrames);
    swapQ.push_back(s);
  endtask

  task automatic pulseVsyncSwap();
    pushSwap();
    vsync = 1'b1;
    applyStimulus();
    vsync = 1'b0;
  endtask

  task automatic pulseClearDone();
    clear_done = 1'b1;
    applyStimulus();
    clear_done = 1'b0;
  endtask

  task automatic pulseFrameEnd();
    gpu_frame_end = 1'b1;
    applyStimulus();
    gpu_frame_end = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      lastCount = 16'h0;
    end else begin
      if (gpu_start === 1'b1) begin
        if (vcQ.size() == 0) checkOutput("gpu_start_unexpected", 64'(gpu_start), 64'(0));
        else checkOutput("gpu_vertex_count", 64'(gpu_vertex_count), 64'(vcQ.pop_front()));
      end
      if (clear_start === 1'b1 || gpu_start === 1'b1)
        checkOutput("start_exclusive", 64'(clear_start & gpu_start), 64'(0));
      if (frame_count !== lastCount) begin
        if (swapQ.size() == 0) begin
          checkOutput("swap_unexpected", 64'(frame_count), 64'(lastCount));
        end else begin
          monS = swapQ.pop_front();
          checkOutput("swap_render_base", 64'(render_base), 64'(monS.render));
          checkOutput("swap_display_base", 64'(display_base), 64'(monS.display));
          checkOutput("swap_frame_count", 64'(frame_count), 64'(monS.count));
        end
        lastCount = frame_count;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; vertex_count_in = '0;
    fb_base0 = BASE0; fb_base1 = BASE1;
    clear_done = 1'b0; gpu_frame_end = 1'b0; vsync = 1'b0; err_clear = 1'b0;
    expBack = 1'b1; expFrames = 0;
    applyStimulus(3);
    checkResetValues("reset");
    reset_n = 1'b1;
    applyStimulus();
    checkOutput("idle_busy", 64'(busy), 64'(0));

    // Basic frame with 36 vertices
    vertex_count_in = 32'd36; enable = 1'b1; vcQ.push_back(36);
    applyStimulus();
    checkOutput("basic_clear_start", 64'(clear_start), 64'(1));
    checkOutput("basic_busy", 64'(busy), 64'(1));
    checkOutput("basic_vcount_latched", 64'(gpu_vertex_count), 64'(36));
    vertex_count_in = 32'd99;
    applyStimulus();
    checkOutput("basic_clear_start_one_cycle", 64'(clear_start), 64'(0));
    pulseClearDone();
    checkOutput("basic_gpu_start", 64'(gpu_start), 64'(1));
    applyStimulus();
    checkOutput("basic_gpu_start_one_cycle", 64'(gpu_start), 64'(0));
    pulseFrameEnd();
    enable = 1'b0;
    checkOutput("basic_no_swap_yet", 64'(frame_count), 64'(0));
    pulseVsyncSwap();
    checkOutput("basic_render_base", 64'(render_base), 64'(BASE1));
    checkOutput("basic_display_base", 64'(display_base), 64'(BASE0));
    checkOutput("basic_frame_count", 64'(frame_count), 64'(1));
    checkOutput("basic_idle", 64'(busy), 64'(0));

    // Zero vertices; stray vsync/frame_end in CLEAR_WAIT are ignored
    vertex_count_in = 32'd0; enable = 1'b1;
    applyStimulus(2);
    vsync = 1'b1; gpu_frame_end = 1'b1;
    applyStimulus();
    vsync = 1'b0; gpu_frame_end = 1'b0;
    checkOutput("zero_stray_vsync_ignored", 64'(frame_count), 64'(1));
    pulseClearDone();
    checkOutput("zero_no_gpu_start", 64'(gpu_start), 64'(0));
    enable = 1'b0;
    pulseVsyncSwap();
    checkOutput("zero_frame_count", 64'(frame_count), 64'(2));
    checkOutput("zero_render_base", 64'(render_base), 64'(BASE0));
    checkOutput("zero_idle", 64'(busy), 64'(0));

    // vsync coincident with gpu_frame_end does not swap
    vertex_count_in = 32'd5; enable = 1'b1; vcQ.push_back(5);
    applyStimulus(2);
    pulseClearDone();
    applyStimulus();
    gpu_frame_end = 1'b1; vsync = 1'b1;
    applyStimulus();
    gpu_frame_end = 1'b0; vsync = 1'b0;
    checkOutput("coinc_no_swap", 64'(frame_count), 64'(2));
    checkOutput("coinc_busy", 64'(busy), 64'(1));
    applyStimulus();
    enable = 1'b0;
    pulseVsyncSwap();
    checkOutput("coinc_swap_next_vsync", 64'(frame_count), 64'(3));
    checkOutput("coinc_idle", 64'(busy), 64'(0));

    // enable dropped in RENDER_WAIT completes the frame
    vertex_count_in = 32'd7; enable = 1'b1; vcQ.push_back(7);
    applyStimulus(2);
    pulseClearDone();
    applyStimulus();
    enable = 1'b0;
    applyStimulus(3);
    checkOutput("disable_busy_render_wait", 64'(busy), 64'(1));
    pulseFrameEnd();
    checkOutput("disable_busy_swap_wait", 64'(busy), 64'(1));
    pulseVsyncSwap();
    checkOutput("disable_idle", 64'(busy), 64'(0));
    checkOutput("disable_frame_count", 64'(frame_count), 64'(4));
    applyStimulus();
    checkOutput("disable_no_restart", 64'(clear_start), 64'(0));

    // Watchdog expiry with clear_done withheld
    vertex_count_in = 32'd9; enable = 1'b1;
    applyStimulus();
    enable = 1'b0;
    applyStimulus();
    applyStimulus(62);
    checkOutput("timeout_not_yet_cycle63", 64'(timeout_err), 64'(0));
    applyStimulus();
    checkOutput("timeout_err_cycle64", 64'(timeout_err), 64'(1));
    checkOutput("timeout_busy", 64'(busy), 64'(1));
    enable = 1'b1;
    pulseClearDone();
    applyStimulus(2);
    checkOutput("error_no_clear_start", 64'(clear_start), 64'(0));
    checkOutput("error_no_gpu_start", 64'(gpu_start), 64'(0));
    checkOutput("error_sticky", 64'(timeout_err), 64'(1));
    enable = 1'b0; err_clear = 1'b1;
    applyStimulus();
    err_clear = 1'b0;
    checkOutput("errclr_timeout_err", 64'(timeout_err), 64'(0));
    checkOutput("errclr_idle", 64'(busy), 64'(0));
    checkOutput("errclr_frame_count", 64'(frame_count), 64'(4));
    checkOutput("errclr_render_base", 64'(render_base), 64'(BASE0));

    // clear_done on the expiry cycle wins over the watchdog
    vertex_count_in = 32'd0; enable = 1'b1;
    applyStimulus();
    enable = 1'b0;
    applyStimulus();
    applyStimulus(62);
    pulseClearDone();
    checkOutput("tie_no_timeout", 64'(timeout_err), 64'(0));
    checkOutput("tie_busy", 64'(busy), 64'(1));
    pulseVsyncSwap();
    checkOutput("tie_frame_count", 64'(frame_count), 64'(5));

    // Asynchronous reset in RENDER_WAIT
    vertex_count_in = 32'd11; enable = 1'b1; vcQ.push_back(11);
    applyStimulus(2);
    pulseClearDone();
    applyStimulus();
    enable = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checkResetValues("midreset");
    expBack = 1'b1; expFrames = 0;
    applyStimulus(2);
    reset_n = 1'b1;
    applyStimulus();
    checkOutput("postreset_idle", 64'(busy), 64'(0));

    // Back-to-back frames: back_sel alternates on each swap
    vertex_count_in = 32'd0; enable = 1'b1;
    applyStimulus();
    for (int f = 0; f < NFRAMES; f++) begin
      checkOutput("run_clear_start", 64'(clear_start), 64'(1));
      applyStimulus();
      pulseClearDone();
      if (f == NFRAMES - 1) enable = 1'b0;
      pulseVsyncSwap();
    end
    applyStimulus();
    checkOutput("run_frame_count", 64'(frame_count), 64'(NFRAMES));
    checkOutput("run_idle", 64'(busy), 64'(0));
    checkOutput("run_render_base", 64'(render_base), 64'(expBack ? BASE0 : BASE1));
    checkOutput("vc_queue_drained", 64'(vcQ.size()), 64'(0));
    checkOutput("swap_queue_drained", 64'(swapQ.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
